// File: rtl/param_dram_ctrl.sv
// Single-bank DRAM controller model with an open-row policy, periodic refresh and a
// row-hit statistic. One request is outstanding at a time; read data returns as a one-cycle pulse.
module param_dram_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROW_W   = 4,
  parameter int unsigned COL_W   = 4,
  parameter int unsigned T_RCD   = 2,
  parameter int unsigned T_RP    = 2,
  parameter int unsigned T_RFC   = 4,
  parameter int unsigned REF_INT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ROW_W+COL_W-1:0] req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   row_open,
  output logic [ROW_W-1:0]       open_row,
  output logic [15:0]            stat_hits
);

  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned T_MAX1 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned T_MAX  = (T_MAX1 > T_RFC) ? T_MAX1 : T_RFC;
  localparam int unsigned TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned REF_W  = $clog2(REF_INT);

  typedef enum logic [2:0] {StIdle, StPrecharge, StActivate, StAccess, StRefresh} state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                tmr_done;
  logic [REF_W-1:0]    ref_cnt_q;
  logic                ref_pend_q;
  logic                for_ref_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic                accept;
  logic                hit;
  logic                ref_wrap;

  assign accept   = req_valid && req_ready;
  assign hit      = row_open && (open_row == req_addr[ADDR_W-1:COL_W]);
  assign ref_wrap = (ref_cnt_q == REF_W'(REF_INT - 1));

  always_comb begin
    tmr_done = 1'b0;
    unique case (state_q)
      StPrecharge: tmr_done = (tmr_q == TMR_W'(T_RP - 1));
      StActivate:  tmr_done = (tmr_q == TMR_W'(T_RCD - 1));
      StRefresh:   tmr_done = (tmr_q == TMR_W'(T_RFC - 1));
      default:     tmr_done = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state logic; refresh has priority in IDLE because req_ready is low while it is pending
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ref_pend_q) begin
          state_d = row_open ? StPrecharge : StRefresh;
        end else if (req_valid) begin
          if (hit)            state_d = StAccess;
          else if (!row_open) state_d = StActivate;
          else                state_d = StPrecharge;
        end
      end
      StPrecharge: if (tmr_done) state_d = for_ref_q ? StRefresh : StActivate;
      StActivate:  if (tmr_done) state_d = StAccess;
      StAccess:    state_d = StIdle;
      StRefresh:   if (tmr_done) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    tmr_d = (state_d != state_q || state_q == StIdle) ? '0 : tmr_q + TMR_W'(1);
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = (state_q == StIdle) && !ref_pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      for_ref_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      row_open   <= 1'b0;
      open_row   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      stat_hits  <= '0;
    end else begin
      ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
      // A wrap wins over the clear so a refresh is never silently dropped
      if (ref_wrap)                              ref_pend_q <= 1'b1;
      else if (state_q == StRefresh && tmr_done) ref_pend_q <= 1'b0;
      if (state_q == StIdle) for_ref_q <= ref_pend_q;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (hit && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      end
      if (state_q == StPrecharge || state_q == StRefresh) row_open <= 1'b0;
      if (state_q == StActivate && tmr_done) begin
        row_open <= 1'b1;
        open_row <= addr_q[ADDR_W-1:COL_W];
      end
      rsp_valid <= (state_q == StAccess) && !we_q;
      if (state_q == StAccess && !we_q) rsp_rdata <= mem[addr_q];
    end
  end

  // Storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (!rst && state_q == StAccess && we_q) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_param_dram_ctrl.sv
// Directed bench for param_dram_ctrl at default parameters: latencies, row policy, refresh
// interaction and mid-operation reset, with hand-computed expectations.
module tb_param_dram_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        row_open;
  logic [3:0]  open_row;
  logic [15:0] stat_hits;

  int checks;
  int failures;
  int unsigned edges;

  param_dram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .row_open  (row_open),
    .open_row  (open_row),
    .stat_hits (stat_hits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; matches the refresh counter value modulo REF_INT
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits for req_ready, then holds the request across the accept edge
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    int k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: req_ready stayed %b, required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Called right after the accept edge; lat counts from accept edge to rsp_valid sampling edge
  task automatic wait_rsp(output int lat);
    int k;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    lat = (rsp_valid === 1'b1) ? k + 1 : -1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata: got %h required 00", rsp_rdata); end
    checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL rst_row_open: got %b required 0", row_open); end
    checks++; if (open_row !== 4'h0) begin failures++; $display("FAIL rst_open_row: got %h required 0", open_row); end
    checks++; if (stat_hits !== 16'h0) begin failures++; $display("FAIL rst_hits: got %h required 0", stat_hits); end
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b1, 8'h12, 8'hA5);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL wr_busy: got %b required 0", req_ready); end
    tick();
    tick();
    checks++; if (row_open !== 1'b1) begin failures++; $display("FAIL wr_row_open: got %b required 1", row_open); end
    checks++; if (open_row !== 4'h1) begin failures++; $display("FAIL wr_open_row: got %h required 1", open_row); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL wr_access_busy: got %b required 0", req_ready); end
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_done_ready: got %b required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_no_rsp: got %b required 0", rsp_valid); end
    issue(1'b0, 8'h12, 8'h00);
    wait_rsp(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL hit_latency: got %0d required 2", lat); end
    checks++; if (rsp_rdata !== 8'hA5) begin failures++; $display("FAIL hit_rdata: got %h required a5", rsp_rdata); end
    checks++; if (stat_hits !== 16'd1) begin failures++; $display("FAIL hit_count: got %0d required 1", stat_hits); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL hit_ready_with_rsp: got %b required 1", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_pulse_width: got %b required 0", rsp_valid); end
  endtask

  task automatic test_row_miss();
    int lat;
    issue(1'b0, 8'h34, 8'h00);
    wait_rsp(lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL miss_latency: got %0d required 6", lat); end
    checks++; if (open_row !== 4'h3) begin failures++; $display("FAIL miss_open_row: got %h required 3", open_row); end
    checks++; if (stat_hits !== 16'd1) begin failures++; $display("FAIL miss_hits: got %0d required 1", stat_hits); end
  endtask

  task automatic test_back_to_back();
    int acc;
    int rsp;
    logic exp_rdy;
    acc = 0;
    rsp = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = {4'h3, 4'(i)};
      exp_rdy   = (i % 2 == 0);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL b2b_ready[%0d]: got %b required %b", i, req_ready, exp_rdy); end
      if (req_ready === 1'b1) acc++;
      if (i > 0 && rsp_valid === 1'b1) rsp++;
      tick();
    end
    req_valid = 1'b0;
    if (rsp_valid === 1'b1) rsp++;
    checks++; if (acc !== 4) begin failures++; $display("FAIL b2b_accepts: got %0d required 4", acc); end
    checks++; if (rsp !== 4) begin failures++; $display("FAIL b2b_responses: got %0d required 4", rsp); end
    checks++; if (stat_hits !== 16'd5) begin failures++; $display("FAIL b2b_hits: got %0d required 5", stat_hits); end
  endtask

  task automatic test_refresh_idle();
    int k;
    int n;
    int lat;
    do_reset();
    issue(1'b1, 8'h25, 8'h3C);
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin tick(); k++; end
    k = 0;
    while (req_ready === 1'b1 && k < 200) begin tick(); k++; end
    checks++; if (edges !== 64) begin failures++; $display("FAIL ref_start_edge: got %0d required 64", edges); end
    checks++; if (row_open !== 1'b1) begin failures++; $display("FAIL ref_row_before: got %b required 1", row_open); end
    n = 0;
    while (req_ready !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n !== 7) begin failures++; $display("FAIL ref_busy_cycles: got %0d required 7", n); end
    checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL ref_row_after: got %b required 0", row_open); end
    issue(1'b0, 8'h25, 8'h00);
    wait_rsp(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ref_closed_latency: got %0d required 4", lat); end
    checks++; if (rsp_rdata !== 8'h3C) begin failures++; $display("FAIL ref_rdata: got %h required 3c", rsp_rdata); end
  endtask

  task automatic test_refresh_during_access();
    int k;
    int n;
    int rsp;
    int lat;
    do_reset();
    issue(1'b1, 8'h50, 8'h77);
    issue(1'b1, 8'h10, 8'h11);
    k = 0;
    while (edges < 61 && k < 100) begin tick(); k++; end
    issue(1'b0, 8'h50, 8'h00);
    wait_rsp(lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL refmiss_latency: got %0d required 6", lat); end
    checks++; if (rsp_rdata !== 8'h77) begin failures++; $display("FAIL refmiss_rdata: got %h required 77", rsp_rdata); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL refmiss_ready_held: got %b required 0", req_ready); end
    n = 0;
    rsp = 0;
    while (req_ready !== 1'b1 && n < 30) begin
      if (rsp_valid === 1'b1) rsp++;
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid === 1'b1) rsp++;
      tick();
    end
    checks++; if (n !== 7) begin failures++; $display("FAIL refmiss_busy_cycles: got %0d required 7", n); end
    checks++; if (rsp !== 1) begin failures++; $display("FAIL refmiss_rsp_count: got %0d required 1", rsp); end
    checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL refmiss_row_after: got %b required 0", row_open); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int rsp;
    do_reset();
    issue(1'b1, 8'h30, 8'h33);
    issue(1'b1, 8'h20, 8'h11);
    issue(1'b0, 8'h20, 8'h00);
    wait_rsp(lat);
    issue(1'b0, 8'h30, 8'h00);
    wait_rsp(lat);
    checks++; if (rsp_rdata !== 8'h33) begin failures++; $display("FAIL mid_pre_rdata: got %h required 33", rsp_rdata); end
    issue(1'b1, 8'h20, 8'h5A);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL mid_rdata: got %h required 00", rsp_rdata); end
    checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL mid_row_open: got %b required 0", row_open); end
    checks++; if (open_row !== 4'h0) begin failures++; $display("FAIL mid_open_row: got %h required 0", open_row); end
    checks++; if (stat_hits !== 16'h0) begin failures++; $display("FAIL mid_hits: got %h required 0", stat_hits); end
    rst = 1'b0;
    rsp = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1) rsp++;
      tick();
    end
    checks++; if (rsp !== 0) begin failures++; $display("FAIL mid_stray_rsp: got %0d required 0", rsp); end
    issue(1'b0, 8'h20, 8'h00);
    wait_rsp(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL mid_read_latency: got %0d required 4", lat); end
    checks++; if (rsp_rdata !== 8'h11) begin failures++; $display("FAIL mid_no_commit: got %h required 11", rsp_rdata); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    test_reset();
    test_write_read();
    test_row_miss();
    test_back_to_back();
    test_refresh_idle();
    test_refresh_during_access();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_dram_ctrl.md
PARAM_DRAM_CTRL -- requirements
Module: param_dram_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_W, 8, data word width
- ROW_W, 4, row address bits
- COL_W, 4, column address bits
- T_RCD, 2, ACTIVATE cycles (>=1)
- T_RP, 2, PRECHARGE cycles (>=1)
- T_RFC, 4, REFRESH cycles (>=1)
- REF_INT, 64, cycles between refresh requests (> T_RP+T_RCD+T_RFC+2)
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge
- rst, in, 1, reset; synchronous, active-high
- req_valid, in, 1, request present
- req_ready, out, 1, controller accepts request this cycle
- req_we, in, 1, 1 = write, 0 = read
- req_addr, in, ROW_W+COL_W, {row, col}; row = upper ROW_W bits
- req_wdata, in, DATA_W, write data
- rsp_valid, out, 1, read data valid (one-cycle pulse)
- rsp_rdata, out, DATA_W, read data; holds last value
- row_open, out, 1, a row is currently open
- open_row, out, ROW_W, index of the open row
- stat_hits, out, 16, saturating row-hit counter
REQ-003 One clock, clk. Reset rst is synchronous and active-high.

Function
REQ-004 Storage: 2^(ROW_W+COL_W) words of DATA_W bits. Storage is not cleared by reset.
REQ-005 FSM states: IDLE, PRECHARGE, ACTIVATE, ACCESS, REFRESH.
REQ-006 req_ready = 1 only in IDLE with refresh_pending = 0. A request is accepted on an edge where req_valid && req_ready.
REQ-007 On accept, the controller latches req_we, req_addr and req_wdata, then moves:
- row open and row matches -> ACCESS (hit); stat_hits increments, saturating at 0xFFFF
- no row open -> ACTIVATE
- row open, different row -> PRECHARGE
REQ-008 PRECHARGE lasts exactly T_RP cycles. It clears row_open, then goes to ACTIVATE, or to REFRESH if entered for refresh.
REQ-009 ACTIVATE lasts exactly T_RCD cycles. It sets row_open = 1 and open_row = latched row, then goes to ACCESS.
REQ-010 ACCESS lasts exactly 1 cycle, then returns to IDLE.
- Write: the word is stored at the ACCESS edge.
- Read: rsp_rdata loads the stored word and rsp_valid = 1 for exactly the following cycle.
REQ-011 Writes produce no response.
REQ-012 Read latency from the accept edge N to the rsp_valid cycle:
- hit: N+2
- closed row: N+2+T_RCD
- row miss: N+2+T_RP+T_RCD
REQ-013 req_ready returns to 1 in the same cycle that rsp_valid is asserted (unless refresh is pending). Back-to-back hits therefore sustain one request per 2 cycles.
REQ-014 Refresh counter: free-running 0..REF_INT-1. At wrap it sets refresh_pending. The counter keeps counting in every state.
REQ-015 Refresh is serviced only from IDLE: row open -> PRECHARGE then REFRESH; otherwise -> REFRESH directly.
REQ-016 REFRESH lasts T_RFC cycles, leaves row_open = 0, clears refresh_pending and returns to IDLE.
REQ-017 Refresh expiry during an in-flight access does not abort it; the refresh waits for IDLE.
REQ-018 Pending refreshes do not accumulate: a second wrap while pending leaves pending = 1.
REQ-019 refresh_pending deasserts req_ready in the same cycle it rises, so a refresh never collides with an accept.
REQ-020 Same-cycle write then read of the same address is impossible (one outstanding request). A read after a write to the same address returns the written data.

Reset
REQ-021 While rst = 1 at an edge:
- FSM -> IDLE; refresh counter = 0; refresh_pending = 0
- row_open = 0; open_row = 0
- rsp_valid = 0; rsp_rdata = 0; stat_hits = 0
REQ-022 req_ready = 1 in the first cycle after reset release.
REQ-023 Reset mid-operation abandons the operation: no write commit and no rsp_valid afterwards.

Verification
REQ-024 Default parameters, from reset: write 0x12 = 0xA5 (closed row), then read 0x12 -> write accepted at N with ACCESS at N+3; read is a hit with rsp_valid 2 cycles after its accept, rsp_rdata = 0xA5, stat_hits = 1.
REQ-025 Row 1 open; read 0x34 -> rsp_valid exactly 6 cycles after accept; open_row = 3; stat_hits unchanged.
REQ-026 req_valid held high with hits to row 3 -> one accept every 2 cycles; stat_hits increments per accept.
REQ-027 Refresh with row open, interval elapsing while idle -> req_ready = 0 for T_RP+T_RFC+1 cycles; row_open = 0 afterwards; the next request to the same row takes the closed-row latency of 4 cycles.
REQ-028 Refresh expiry during a row-miss read -> read completes with its normal latency; then the refresh sequence runs; no lost or duplicated rsp_valid.
REQ-029 rst asserted during ACTIVATE of a write to 0x20 = 0x5A -> all REQ-021 values; a later read of 0x20 does not return 0x5A unless it was previously stored.
